// File: rtl/ucounter_if.sv
// Control, limit and status signals of the up/down limit counter, grouped so that
// a controller and the counter share one bundle.
interface ucounter_if #(
    parameter int WIDTH = 8,
    parameter int STEPW = 4
);
    logic             set;
    logic             load;
    logic [WIDTH-1:0] preld_val;
    logic             en;
    logic             updown;
    logic             wrapstop;
    logic [STEPW-1:0] step;
    logic [WIDTH-1:0] lo_lim;
    logic [WIDTH-1:0] hi_lim;
    logic [WIDTH-1:0] dcount;
    logic             overflow;
    logic             underflow;
    logic             cfg_err;

    modport master (
        output set, load, preld_val, en, updown, wrapstop, step, lo_lim, hi_lim,
        input  dcount, overflow, underflow, cfg_err
    );

    modport slave (
        input  set, load, preld_val, en, updown, wrapstop, step, lo_lim, hi_lim,
        output dcount, overflow, underflow, cfg_err
    );
endinterface

// File: rtl/ucounter_n.sv
// Up/down counter with programmable step and inclusive [lo_lim, hi_lim] range,
// wrapping or saturating at the limits with one-cycle boundary pulses.
module ucounter_n #(
    parameter int WIDTH = 8,
    parameter int STEPW = 4
) (
    input  logic       clk,
    input  logic       reset,
    ucounter_if.slave  cnt
);
    logic [WIDTH-1:0] dcount_reg, dcount_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic             cfg_err;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   lo_plus_step;
    logic             counting;

    assign cfg_err = (cnt.lo_lim > cnt.hi_lim);

    // All boundary arithmetic carries one extra bit so a sum past 2^WIDTH-1 is
    // still seen as beyond hi_lim instead of wrapping back into range.
    assign step_ext     = {{(WIDTH + 1 - STEPW){1'b0}}, cnt.step};
    assign count_ext    = {1'b0, dcount_reg};
    assign up_sum       = count_ext + step_ext;
    assign lo_plus_step = {1'b0, cnt.lo_lim} + step_ext;
    assign counting     = cnt.en && (cnt.step != '0) && !cfg_err;

    always_comb begin
        dcount_next    = dcount_reg;
        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (cnt.set) begin
            dcount_next = cnt.hi_lim;
        end else if (cnt.load) begin
            dcount_next = cnt.preld_val;
        end else if (counting) begin
            if (cnt.updown) begin
                if (up_sum <= {1'b0, cnt.hi_lim}) begin
                    dcount_next = up_sum[WIDTH-1:0];
                end else if (!cnt.wrapstop) begin
                    dcount_next   = cnt.lo_lim;
                    overflow_next = 1'b1;
                end else begin
                    // Already parked at hi_lim: holding there is not a new event.
                    dcount_next   = cnt.hi_lim;
                    overflow_next = (dcount_reg != cnt.hi_lim);
                end
            end else begin
                if (count_ext >= lo_plus_step) begin
                    dcount_next = dcount_reg - cnt.step;
                end else if (!cnt.wrapstop) begin
                    dcount_next    = cnt.hi_lim;
                    underflow_next = 1'b1;
                end else begin
                    dcount_next    = cnt.lo_lim;
                    underflow_next = (dcount_reg != cnt.lo_lim);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcount_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            dcount_reg    <= dcount_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign cnt.dcount    = dcount_reg;
    assign cnt.overflow  = overflow_reg;
    assign cnt.underflow = underflow_reg;
    assign cnt.cfg_err   = cfg_err;
endmodule

// File: tb/tb_ucounter_n.sv
// Directed-vector bench for ucounter_n (WIDTH=8, STEPW=4) followed by a seeded
// random control sequence checked against an integer reference model.
module tb_ucounter_n;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    ucounter_if #(.WIDTH(8), .STEPW(4)) cnt ();

    ucounter_n #(.WIDTH(8), .STEPW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .cnt   (cnt.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; outputs settle and are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t dcount=%02h ov=%b un=%b cfg_err=%b",
                 $time, cnt.dcount, cnt.overflow, cnt.underflow, cnt.cfg_err);
    endtask

    task automatic expect_out(input string tag, input int d, input bit ov, input bit un);
        check({tag, ".dcount"}, 32'(cnt.dcount), 32'(d));
        check({tag, ".ov"}, 32'(cnt.overflow), 32'(ov));
        check({tag, ".un"}, 32'(cnt.underflow), 32'(un));
    endtask

    task automatic do_load(input int v);
        cnt.load = 1'b1;
        cnt.preld_val = 8'(v);
        tick();
        cnt.load = 1'b0;
    endtask

    task automatic config_cnt(input int lo, input int hi, input int st, input bit up, input bit ws);
        cnt.lo_lim   = 8'(lo);
        cnt.hi_lim   = 8'(hi);
        cnt.step     = 4'(st);
        cnt.updown   = up;
        cnt.wrapstop = ws;
    endtask

    int md;
    bit mov, mun;

    initial begin
        n_vec = 0;
        n_miss = 0;
        reset = 1'b1;
        cnt.set = 1'b0;
        cnt.load = 1'b0;
        cnt.preld_val = '0;
        cnt.en = 1'b0;
        config_cnt(0, 255, 1, 1'b1, 1'b0);
        tick();
        tick();
        expect_out("reset", 0, 1'b0, 1'b0);
        check("reset.cfg_err", 32'(cnt.cfg_err), 32'd0);
        reset = 1'b0;

        // Full-range wrap on the way up.
        do_load(8'hF8);
        expect_out("ld_f8", 8'hF8, 1'b0, 1'b0);
        cnt.en = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            expect_out("wrap_up", 8'hF8 + i, 1'b0, 1'b0);
        end
        tick();
        expect_out("wrap_up_edge", 8'h00, 1'b1, 1'b0);
        tick();
        expect_out("wrap_up_after", 8'h01, 1'b0, 1'b0);

        // Saturating up, step 3, range 10..20.
        config_cnt(10, 20, 3, 1'b1, 1'b1);
        do_load(16);
        tick(); expect_out("sat_up1", 19, 1'b0, 1'b0);
        tick(); expect_out("sat_up2", 20, 1'b1, 1'b0);
        tick(); expect_out("sat_up3", 20, 1'b0, 1'b0);
        do_load(17);
        tick(); expect_out("exact_hi", 20, 1'b0, 1'b0);

        // Extra-bit arithmetic: 0xFE + 4 must not wrap to 0x02.
        config_cnt(0, 255, 4, 1'b1, 1'b1);
        do_load(8'hFE);
        tick(); expect_out("no_silent_wrap", 8'hFF, 1'b1, 1'b0);

        // Wrapping down, step 4.
        config_cnt(10, 20, 4, 1'b0, 1'b0);
        do_load(13);
        tick(); expect_out("wrap_dn", 20, 1'b0, 1'b1);
        do_load(14);
        tick(); expect_out("exact_lo", 10, 1'b0, 1'b0);

        // Saturating down.
        config_cnt(10, 20, 3, 1'b0, 1'b1);
        do_load(12);
        tick(); expect_out("sat_dn1", 10, 1'b0, 1'b1);
        tick(); expect_out("sat_dn2", 10, 1'b0, 1'b0);

        // Loaded value above hi_lim counting up, wrap mode.
        config_cnt(10, 20, 1, 1'b1, 1'b0);
        do_load(200);
        expect_out("ld_out_of_range", 200, 1'b0, 1'b0);
        tick(); expect_out("above_hi_up", 10, 1'b1, 1'b0);

        // Priority.
        reset = 1'b1; cnt.set = 1'b1; cnt.load = 1'b1; cnt.preld_val = 8'h5A;
        tick(); expect_out("prio_rst", 0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); expect_out("prio_set", 20, 1'b0, 1'b0);
        cnt.set = 1'b0;
        tick(); expect_out("prio_load", 8'h5A, 1'b0, 1'b0);
        cnt.load = 1'b0;

        // Invalid limits and zero step hold the count.
        config_cnt(30, 20, 1, 1'b1, 1'b0);
        #1 check("cfg_err_hi", 32'(cnt.cfg_err), 32'd1);
        tick(); expect_out("cfg_err_hold", 8'h5A, 1'b0, 1'b0);
        config_cnt(0, 255, 0, 1'b1, 1'b0);
        #1 check("cfg_err_lo", 32'(cnt.cfg_err), 32'd0);
        tick(); expect_out("step0_hold", 8'h5A, 1'b0, 1'b0);

        // Reset mid-count.
        config_cnt(0, 255, 1, 1'b1, 1'b0);
        do_load(8'h42);
        reset = 1'b1;
        tick(); expect_out("mid_reset", 0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); expect_out("post_reset", 1, 1'b0, 1'b0);

        // Random sequence against the reference model.
        md = int'(cnt.dcount);
        for (int k = 0; k < 300; k++) begin
            int lo, hi, st, pv;
            bit up, ws, en, ld, st_set, rs;
            lo = $urandom_range(0, 120);
            hi = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255) : $urandom_range(lo, 255);
            st = $urandom_range(0, 15);
            up = 1'($urandom_range(0, 1));
            ws = 1'($urandom_range(0, 1));
            en = ($urandom_range(0, 7) != 0);
            ld = ($urandom_range(0, 9) == 0);
            st_set = ($urandom_range(0, 29) == 0);
            rs = ($urandom_range(0, 39) == 0);
            pv = $urandom_range(0, 255);
            config_cnt(lo, hi, st, up, ws);
            cnt.en = en; cnt.load = ld; cnt.set = st_set; cnt.preld_val = 8'(pv);
            reset = rs;
            mov = 1'b0;
            mun = 1'b0;
            if (rs) md = 0;
            else if (st_set) md = hi;
            else if (ld) md = pv;
            else if (en && st != 0 && lo <= hi) begin
                if (up) begin
                    if (md + st <= hi) md = md + st;
                    else if (!ws) begin md = lo; mov = 1'b1; end
                    else begin mov = (md != hi); md = hi; end
                end else begin
                    if (md - st >= lo) md = md - st;
                    else if (!ws) begin md = hi; mun = 1'b1; end
                    else begin mun = (md != lo); md = lo; end
                end
            end
            tick();
            expect_out("rand", md, mov, mun);
            check("rand.cfg_err", 32'(cnt.cfg_err), 32'(lo > hi));
        end
        reset = 1'b0;
        cnt.set = 1'b0;
        cnt.load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ucounter_n.md
UCOUNTER_N -- requirements
Module: ucounter_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter/data width (legal 2..32).
REQ-002 SHALL have parameter STEPW, default 4, step-size width (legal 1..WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port set  input  1  sync set: dcount <= hi_lim.
REQ-006 SHALL have port load  input  1  sync load: dcount <= preld_val.
REQ-007 SHALL have port preld_val  input  WIDTH  preload value.
REQ-008 SHALL have port en  input  1  count enable.
REQ-009 SHALL have port updown  input  1  1 = count up, 0 = count down.
REQ-010 SHALL have port wrapstop  input  1  0 = wrap at limit, 1 = stop (saturate) at limit.
REQ-011 SHALL have port step  input  STEPW  unsigned increment per enabled cycle.
REQ-012 SHALL have ports lo_lim, hi_lim  input  WIDTH  inclusive count range.
REQ-013 SHALL have port dcount  output  WIDTH  registered count.
REQ-014 SHALL have ports overflow, underflow  output  1  registered one-cycle boundary pulses.
REQ-015 SHALL have port cfg_err  output  1  combinational, high while lo_lim > hi_lim.

Function
REQ-016 SHALL apply priority reset > set > load > counting; one action per cycle.
REQ-017 SHALL update dcount one cycle after the controlling input is sampled (latency 1); flags registered in the same cycle as the dcount update.
REQ-018 SHALL hold dcount and deassert both flags when en=0, step=0 or cfg_err=1 (and no set/load/reset).
REQ-019 SHALL load preld_val unclamped; set/load SHALL deassert both flags that cycle.
REQ-020 SHALL compute up-sum dcount+step and down-test dcount-step in WIDTH+1 bits; no silent WIDTH-bit wrap.
REQ-021 Up, dcount+step <= hi_lim: dcount <= dcount+step, overflow=0 (exact hit of hi_lim is not overflow).
REQ-022 Up, dcount+step > hi_lim, wrapstop=0: dcount <= lo_lim, overflow=1 for one cycle.
REQ-023 Up, dcount+step > hi_lim, wrapstop=1: dcount <= hi_lim; overflow=1 only if previous dcount != hi_lim, else 0 (saturated hold).
REQ-024 Down, dcount >= lo_lim+step: dcount <= dcount-step, underflow=0 (exact hit of lo_lim is not underflow).
REQ-025 Down, dcount < lo_lim+step, wrapstop=0: dcount <= hi_lim, underflow=1 for one cycle.
REQ-026 Down, dcount < lo_lim+step, wrapstop=1: dcount <= lo_lim; underflow=1 only if previous dcount != lo_lim.
REQ-027 SHALL treat a loaded value outside [lo_lim,hi_lim] by the same rules (e.g. above hi_lim counting up -> boundary case).
REQ-028 SHALL never assert overflow and underflow in the same cycle.
REQ-029 updown, wrapstop, step, limit changes SHALL take effect on the next enabled edge with no extra latency.

Reset
REQ-030 reset=1 at a rising edge SHALL force dcount=0, overflow=0, underflow=0, regardless of set/load/en.
REQ-031 Reset mid-count SHALL discard the in-progress step; counting resumes from 0 on the first edge after reset falls.
REQ-032 No output SHALL change asynchronously on reset; cfg_err depends only on limits.

Verification (WIDTH=8, STEPW=4)
REQ-033 lo=0, hi=255, step=1, up, wrap; load 0xF8, run 8 edges -> 0xF9..0xFF, then 0x00 with overflow=1 for exactly one cycle.
REQ-034 lo=10, hi=20, step=3, up, stop; load 16 -> 19, 20 (overflow=1), 20 (overflow=0) held.
REQ-035 lo=10, hi=20, step=4, down, wrap; load 13 -> 20 with underflow=1; load 14 -> 10, underflow=0.
REQ-036 reset, set, load all high same edge -> dcount=0; set+load -> dcount=hi_lim; load+en -> preld_val.
REQ-037 lo=30, hi=20 with en=1 -> cfg_err=1, dcount held, no flags; step=0 -> dcount held.
REQ-038 reset asserted mid-count at dcount=0x42 -> next edge 0x00, flags 0; random up/down/mode sequence vs. reference model, zero mismatches.
